// File: rtl/cpu_dbg_pkg.sv
// Shared encodings for the CPU run-control unit: command opcodes, halt causes
// and run-control FSM states.
package cpu_dbg_pkg;

   typedef enum logic [1:0] {
      OP_HALT  = 2'b00,
      OP_STEP  = 2'b01,
      OP_RUN   = 2'b10,
      OP_RUN_N = 2'b11
   } cmd_op_e;

   typedef enum logic [1:0] {
      CAUSE_RESET = 2'b00,
      CAUSE_REQ   = 2'b01,
      CAUSE_BP    = 2'b10,
      CAUSE_DONE  = 2'b11
   } halt_cause_e;

   typedef enum logic [1:0] {
      ST_HALTED = 2'b00,
      ST_STEP   = 2'b01,
      ST_RUN    = 2'b10,
      ST_RUN_N  = 2'b11
   } state_e;

endpackage

// File: rtl/dbg_trace_buf.sv
// Circular trace buffer of retired instructions; when full, a write overwrites
// the oldest entry and the count saturates at DEPTH.
module dbg_trace_buf #(
   parameter int unsigned W     = 64,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [W-1:0]             wr_data,
   input  logic                     rd_en,
   output logic [W-1:0]             rd_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]    mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            full;
   logic            do_rd;

   assign full  = (count == FULL_CNT);
   assign do_rd = rd_en & (count != '0);

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr] <= wr_data;
   end

   // A read in the same cycle as an overwrite sees the old oldest entry, and
   // the read pointer advances only once for both.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         rd_data <= '0;
      end else begin
         if (do_rd)
            rd_data <= mem[rd_ptr];
         if (wr_en)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_rd || (wr_en && full))
            rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, do_rd})
            2'b10:   if (!full) count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/cpu_debug_ctrl.sv
// Run-control unit for the single-cycle CPU: halt/step/run/run-N via cpu_ce,
// PC breakpoints, optional retire trace enabled by CPU_DBG_TRACE_EN.
module cpu_debug_ctrl
   import cpu_dbg_pkg::*;
#(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned NUM_BP      = 2,
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned TRACE_DEPTH = 16
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            cmd_valid,
   input  logic [1:0]                      cmd_op,
   input  logic [CNT_W-1:0]                cmd_count,
   output logic                            cmd_ready,
   input  logic                            halt_req,
   input  logic [NUM_BP-1:0]               bp_en,
   input  logic [NUM_BP*XLEN-1:0]          bp_addr,
   input  logic [XLEN-1:0]                 pc,
   input  logic [XLEN-1:0]                 idata,
   output logic                            cpu_ce,
   output logic                            halted,
   output logic [1:0]                      halt_cause,
   input  logic                            tr_rd_en,
   output logic [2*XLEN-1:0]               tr_rd_data,
   output logic [$clog2(TRACE_DEPTH):0]    tr_count
);

   state_e             state, state_next;
   halt_cause_e        cause, cause_next;
   logic [CNT_W-1:0]   cnt, cnt_next;
   logic               skip_bp, skip_next;
   logic [NUM_BP-1:0]  bp_match;
   logic               bp_hit;
   logic               bp_stop;
   logic               ce;

   for (genvar i = 0; i < NUM_BP; i++) begin : g_bp
      assign bp_match[i] = bp_en[i] & (pc == bp_addr[i*XLEN +: XLEN]);
   end
   assign bp_hit = |bp_match;

   // The first retire after a resume ignores a match so RUN from a BP PC advances.
   assign bp_stop = bp_hit & ~skip_bp;

   always_comb begin
      state_next = state;
      cause_next = cause;
      cnt_next   = cnt;
      skip_next  = skip_bp;
      ce         = 1'b0;
      case (state)
         ST_HALTED: begin
            if (cmd_valid) begin
               case (cmd_op_e'(cmd_op))
                  OP_STEP: state_next = ST_STEP;
                  OP_RUN: begin
                     state_next = ST_RUN;
                     skip_next  = 1'b1;
                  end
                  OP_RUN_N: begin
                     if (cmd_count == '0) begin
                        cause_next = CAUSE_DONE;
                     end else begin
                        state_next = ST_RUN_N;
                        cnt_next   = cmd_count;
                        skip_next  = 1'b1;
                     end
                  end
                  default: ;
               endcase
            end
         end
         ST_STEP: begin
            state_next = ST_HALTED;
            if (halt_req) begin
               cause_next = CAUSE_REQ;
            end else begin
               ce         = 1'b1;
               cause_next = CAUSE_DONE;
            end
         end
         ST_RUN: begin
            if (halt_req) begin
               state_next = ST_HALTED;
               cause_next = CAUSE_REQ;
            end else if (bp_stop) begin
               state_next = ST_HALTED;
               cause_next = CAUSE_BP;
            end else begin
               ce        = 1'b1;
               skip_next = 1'b0;
            end
         end
         ST_RUN_N: begin
            if (halt_req) begin
               state_next = ST_HALTED;
               cause_next = CAUSE_REQ;
            end else if (bp_stop) begin
               state_next = ST_HALTED;
               cause_next = CAUSE_BP;
            end else if (cnt == '0) begin
               state_next = ST_HALTED;
               cause_next = CAUSE_DONE;
            end else begin
               ce        = 1'b1;
               skip_next = 1'b0;
               cnt_next  = cnt - 1'b1;
               if (cnt == CNT_W'(1)) begin
                  state_next = ST_HALTED;
                  cause_next = CAUSE_DONE;
               end
            end
         end
         default: begin
            state_next = ST_HALTED;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_HALTED;
         cause     <= CAUSE_RESET;
         cnt       <= '0;
         skip_bp   <= 1'b0;
         halted    <= 1'b1;
         cmd_ready <= 1'b1;
      end else begin
         state     <= state_next;
         cause     <= cause_next;
         cnt       <= cnt_next;
         skip_bp   <= skip_next;
         halted    <= (state_next == ST_HALTED);
         cmd_ready <= (state_next == ST_HALTED);
      end
   end

   // Gated by registered state, so the enable drops as soon as reset clears it.
   assign cpu_ce     = ce;
   assign halt_cause = cause;

`ifdef CPU_DBG_TRACE_EN
   dbg_trace_buf #(
      .W     (2*XLEN),
      .DEPTH (TRACE_DEPTH)
   ) u_trace (
      .clk     (clk),
      .rst     (reset),
      .wr_en   (ce),
      .wr_data ({pc, idata}),
      .rd_en   (tr_rd_en),
      .rd_data (tr_rd_data),
      .count   (tr_count)
   );
`else
   logic unused_trace_in;
   assign unused_trace_in = ^{tr_rd_en, idata};
   assign tr_rd_data = '0;
   assign tr_count   = '0;
`endif

endmodule

// File: tb/tb_cpu_debug_ctrl.sv
// Directed scoreboard bench for cpu_debug_ctrl; a tiny CPU model advances pc by 4 per cpu_ce.
module tb_cpu_debug_ctrl;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned NBP   = 2;
   localparam int unsigned CW    = 16;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned TRW   = $clog2(DEPTH) + 1;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              cmd_valid = 1'b0;
   logic [1:0]        cmd_op = 2'b00;
   logic [CW-1:0]     cmd_count = '0;
   logic              cmd_ready;
   logic              halt_req = 1'b0;
   logic [NBP-1:0]    bp_en = '0;
   logic [NBP*XLEN-1:0] bp_addr = '0;
   logic [XLEN-1:0]   pc = '0;
   logic [XLEN-1:0]   idata;
   logic              cpu_ce;
   logic              halted;
   logic [1:0]        halt_cause;
   logic              tr_rd_en = 1'b0;
   logic [2*XLEN-1:0] tr_rd_data;
   logic [TRW-1:0]    tr_count;

   logic              pc_load = 1'b0;
   logic [XLEN-1:0]   load_val = '0;

   int vectors = 0;
   int miscompares = 0;
   logic [XLEN-1:0] exp_q[$];

   cpu_debug_ctrl #(
      .XLEN(XLEN), .NUM_BP(NBP), .CNT_W(CW), .TRACE_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
      .cmd_count(cmd_count), .cmd_ready(cmd_ready), .halt_req(halt_req),
      .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .idata(idata),
      .cpu_ce(cpu_ce), .halted(halted), .halt_cause(halt_cause),
      .tr_rd_en(tr_rd_en), .tr_rd_data(tr_rd_data), .tr_count(tr_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (pc_load)     pc <= load_val;
      else if (cpu_ce) pc <= pc + 32'd4;
   end
   assign idata = pc ^ 32'hA5A5_0000;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic load_pc(input logic [XLEN-1:0] v);
      @(posedge clk); #1 pc_load = 1'b1; load_val = v;
      @(posedge clk); #1 pc_load = 1'b0;
   endtask

   task automatic do_cmd(input logic [1:0] op, input logic [CW-1:0] n);
      @(posedge clk); #1 cmd_valid = 1'b1; cmd_op = op; cmd_count = n;
      @(posedge clk); #1 cmd_valid = 1'b0;
   endtask

   task automatic push_run(input logic [XLEN-1:0] start, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(start + XLEN'(4*i));
   endtask

   // Samples each negedge after acceptance until halted; pops one expected pc per cpu_ce.
   task automatic watch(input int budget, output int cycles);
      logic done;
      logic [XLEN-1:0] e;
      done = 1'b0;
      cycles = 0;
      for (int i = 0; i < budget && !done; i++) begin
         @(negedge clk);
         cycles++;
         if (cpu_ce) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            check("ce_pc", 64'(pc), 64'(e));
         end
         if (halted) done = 1'b1;
      end
      check("halt_reached", 64'(done), 64'd1);
      check("ce_all_seen", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   task automatic tr_pop();
      @(posedge clk); #1 tr_rd_en = 1'b1;
      @(posedge clk); #1 tr_rd_en = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int cyc;
      logic [XLEN-1:0] tp;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_halted", 64'(halted), 64'd1);
      check("rst_cause", 64'(halt_cause), 64'd0);
      check("rst_ready", 64'(cmd_ready), 64'd1);
      check("rst_ce", 64'(cpu_ce), 64'd0);
      check("rst_trcnt", 64'(tr_count), 64'd0);
      check("rst_trdata", tr_rd_data, 64'd0);
      #1 reset = 1'b0;

      // STEP x3
      for (int s = 0; s < 3; s++) begin
         push_run(XLEN'(4*s), 1);
         do_cmd(2'b01, '0);
         watch(10, cyc);
         check("step_cycles", 64'(cyc), 64'd2);
         check("step_cause", 64'(halt_cause), 64'd3);
      end
      check("step_pc", 64'(pc), 64'h0c);

      // RUN_N 5 then RUN_N 0
      push_run(32'h0c, 5);
      do_cmd(2'b11, 16'd5);
      watch(20, cyc);
      check("runn_cycles", 64'(cyc), 64'd6);
      check("runn_cause", 64'(halt_cause), 64'd3);
      do_cmd(2'b11, 16'd0);
      watch(5, cyc);
      check("runn0_cycles", 64'(cyc), 64'd1);
      check("runn0_cause", 64'(halt_cause), 64'd3);
      check("runn0_pc", 64'(pc), 64'h20);

      // breakpoints
      bp_en = 2'b01;
      bp_addr = {32'h20, 32'h10};
      load_pc(32'h0);
      push_run(32'h0, 4);
      do_cmd(2'b10, '0);
      watch(20, cyc);
      check("bp_cause", 64'(halt_cause), 64'd2);
      check("bp_pc", 64'(pc), 64'h10);
      bp_en = 2'b11;
      push_run(32'h10, 4);
      do_cmd(2'b10, '0);
      watch(20, cyc);
      check("bp1_cause", 64'(halt_cause), 64'd2);
      check("bp1_pc", 64'(pc), 64'h20);

      // halt_req at cycle 7
      bp_en = 2'b00;
      load_pc(32'h100);
      do_cmd(2'b10, '0);
      repeat (6) @(posedge clk);
      #1 halt_req = 1'b1;
      @(negedge clk);
      check("req_ce_low", 64'(cpu_ce), 64'd0);
      @(posedge clk); #1 halt_req = 1'b0;
      @(negedge clk);
      check("req_halted", 64'(halted), 64'd1);
      check("req_cause", 64'(halt_cause), 64'd1);
      check("req_pc", 64'(pc), 64'h118);

      // halt_req and BP hit in the same cycle
      bp_en = 2'b01;
      load_pc(32'h0);
      do_cmd(2'b10, '0);
      repeat (4) @(posedge clk);
      #1 halt_req = 1'b1;
      @(negedge clk);
      check("reqbp_ce_low", 64'(cpu_ce), 64'd0);
      @(posedge clk); #1 halt_req = 1'b0;
      @(negedge clk);
      check("reqbp_cause", 64'(halt_cause), 64'd1);
      check("reqbp_pc", 64'(pc), 64'h10);

      // trace
      bp_en = 2'b00;
      load_pc(32'h0);
      push_run(32'h0, 20);
      do_cmd(2'b11, 16'd20);
      watch(40, cyc);
      check("run20_cycles", 64'(cyc), 64'd21);
`ifdef CPU_DBG_TRACE_EN
      check("tr_full", 64'(tr_count), 64'd16);
      for (int k = 0; k < 16; k++) begin
         tr_pop();
         tp = 32'h10 + XLEN'(4*k);
         check("tr_pop", tr_rd_data, {tp, tp ^ 32'hA5A5_0000});
      end
      check("tr_empty", 64'(tr_count), 64'd0);
      tr_pop();
      tp = 32'h4c;
      check("tr_pop_empty_hold", tr_rd_data, {tp, tp ^ 32'hA5A5_0000});
      check("tr_pop_empty_cnt", 64'(tr_count), 64'd0);
      // refill, then write and read in the same cycle while full
      do_cmd(2'b11, 16'd16);
      repeat (20) @(posedge clk);
      check("tr_refill", 64'(tr_count), 64'd16);
      do_cmd(2'b11, 16'd1);
      tr_rd_en = 1'b1;
      @(posedge clk); #1 tr_rd_en = 1'b0;
      @(negedge clk);
      tp = 32'h50;
      check("tr_wr_rd_data", tr_rd_data, {tp, tp ^ 32'hA5A5_0000});
      check("tr_wr_rd_cnt", 64'(tr_count), 64'd16);
      tr_pop();
      tp = 32'h54;
      check("tr_after_ovw", tr_rd_data, {tp, tp ^ 32'hA5A5_0000});
`else
      tr_pop();
      check("tr_off_cnt", 64'(tr_count), 64'd0);
      check("tr_off_data", tr_rd_data, 64'd0);
`endif

      // reset mid RUN_N
      do_cmd(2'b11, 16'd100);
      repeat (3) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("arst_ce", 64'(cpu_ce), 64'd0);
      check("arst_halted", 64'(halted), 64'd1);
      check("arst_cause", 64'(halt_cause), 64'd0);
      check("arst_trcnt", 64'(tr_count), 64'd0);
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      check("post_rst_ce", 64'(cpu_ce), 64'd0);
      check("post_rst_ready", 64'(cmd_ready), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
